// File: rtl/qar_pkg.sv
// qar_pkg: shared widths, load funct3 codes, writeback entry type and load extraction.
package qar_pkg;
  localparam int XLEN = 32;
  localparam int REG_ADDR_W = 5;
  localparam logic [2:0] F3_LB = 3'b000;
  localparam logic [2:0] F3_LH = 3'b001;
  localparam logic [2:0] F3_LW = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  typedef struct packed {
    logic [REG_ADDR_W-1:0] rd;
    logic [XLEN-1:0] data;
  } wb_ent_t;
  function automatic logic [XLEN-1:0] load_extract(input logic [XLEN-1:0] rdata, input logic [2:0] f3,
                                                   input logic [1:0] off);
    logic [XLEN-1:0] b;
    logic [XLEN-1:0] h;
    b = rdata >> {off, 3'b000};
    h = rdata >> {off[1], 4'b0000};
    return f3 == F3_LB  ? {{(XLEN-8){b[7]}}, b[7:0]} :
           f3 == F3_LH  ? {{(XLEN-16){h[15]}}, h[15:0]} :
           f3 == F3_LBU ? {{(XLEN-8){1'b0}}, b[7:0]} :
           f3 == F3_LHU ? {{(XLEN-16){1'b0}}, h[15:0]} : rdata;
  endfunction
endpackage

// File: rtl/qar_wb_lq.sv
// qar_wb_lq: synchronous load-queue FIFO with wrap-around pointers and occupancy count.
module qar_wb_lq #(
  parameter int W = 37,
  parameter int DEPTH = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push_i,
  input  logic         pop_i,
  input  logic [W-1:0] wdata_i,
  output logic [W-1:0] rdata_o,
  output logic         full_o,
  output logic         empty_o
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0] mem_q [DEPTH];
  logic [AW-1:0] wp_q, rp_q;
  logic [AW:0] cnt_q, cnt_d;
  assign cnt_d = cnt_q + (AW+1)'(push_i) - (AW+1)'(pop_i);
  always_ff @(posedge clk) begin
    if (rst) begin
      wp_q <= '0;
      rp_q <= '0;
      cnt_q <= '0;
    end else begin
      wp_q <= wp_q + AW'(push_i);
      rp_q <= rp_q + AW'(pop_i);
      cnt_q <= cnt_d;
    end
  end
  always_ff @(posedge clk) if (push_i) mem_q[wp_q] <= wdata_i;
  assign rdata_o = mem_q[rp_q];
  assign full_o = cnt_q == (AW+1)'(DEPTH);
  assign empty_o = cnt_q == '0;
endmodule

// File: rtl/qar_writeback.sv
// qar_writeback: merges ALU results and queued, extended loads onto the registered regfile write port.
module qar_writeback
  import qar_pkg::*;
#(
  parameter int LQ_DEPTH = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  alu_valid,
  output logic                  alu_ready,
  input  logic [REG_ADDR_W-1:0] alu_rd,
  input  logic [XLEN-1:0]       alu_data,
  input  logic                  lsu_valid,
  output logic                  lsu_ready,
  input  logic [REG_ADDR_W-1:0] lsu_rd,
  input  logic [XLEN-1:0]       lsu_rdata,
  input  logic [2:0]            lsu_funct3,
  input  logic [1:0]            lsu_addr_lo,
  input  logic                  wb_hold,
  output logic                  rf_we,
  output logic [REG_ADDR_W-1:0] rf_waddr,
  output logic [XLEN-1:0]       rf_wdata,
  output logic [31:0]           retire_count
);
  localparam int SW = $clog2(STARVE_LIMIT + 1);
  wb_ent_t lq_in, lq_out, sel;
  logic lq_full, lq_empty, push, grant_lq, grant_alu, grant, starved;
  logic [SW-1:0] starve_q, starve_d;
  assign lsu_ready = !rst && !lq_full;
  assign push = lsu_valid && lsu_ready;
  assign lq_in = '{rd: lsu_rd, data: load_extract(lsu_rdata, lsu_funct3, lsu_addr_lo)};
  qar_wb_lq #(.W($bits(wb_ent_t)), .DEPTH(LQ_DEPTH)) u_lq (
    .clk(clk), .rst(rst), .push_i(push), .pop_i(grant_lq), .wdata_i(lq_in),
    .rdata_o(lq_out), .full_o(lq_full), .empty_o(lq_empty)
  );
  // Loads win by default; a saturated starve count hands one slot to a waiting ALU result.
  assign starved = alu_valid && starve_q == SW'(STARVE_LIMIT);
  assign grant_lq = !rst && !wb_hold && !lq_empty && !starved;
  assign grant_alu = !rst && !wb_hold && !grant_lq && alu_valid;
  assign grant = grant_lq || grant_alu;
  assign alu_ready = grant_alu;
  assign sel = grant_lq ? lq_out : '{rd: alu_rd, data: alu_data};
  assign starve_d = grant_alu ? '0 : (alu_valid && starve_q != SW'(STARVE_LIMIT)) ? starve_q + 1'b1 : starve_q;
  always_ff @(posedge clk) begin
    if (rst) begin
      rf_we <= 1'b0;
      rf_waddr <= '0;
      rf_wdata <= '0;
      retire_count <= '0;
      starve_q <= '0;
    end else begin
      rf_we <= grant && sel.rd != '0;
      if (grant) begin
        rf_waddr <= sel.rd;
        rf_wdata <= sel.data;
      end
      retire_count <= retire_count + 32'(grant);
      starve_q <= starve_d;
    end
  end
endmodule

// File: tb/tb_qar_writeback.sv
// tb_qar_writeback: directed scoreboard bench for the writeback stage.
module tb_qar_writeback;
  import qar_pkg::*;
  logic clk = 0, rst = 1;
  logic alu_valid = 0, lsu_valid = 0, wb_hold = 0;
  logic alu_ready, lsu_ready, rf_we;
  logic [4:0] alu_rd = 0, lsu_rd = 0, rf_waddr;
  logic [31:0] alu_data = 0, lsu_rdata = 0, rf_wdata, retire_count;
  logic [2:0] lsu_funct3 = 0;
  logic [1:0] lsu_addr_lo = 0;
  int checks = 0, failures = 0;
  logic [36:0] exp_q[$];
  typedef struct {
    logic [4:0] rd;
    logic [2:0] f3;
    logic [1:0] off;
    logic [31:0] rdata;
    logic [31:0] res;
  } ld_t;
  ld_t lds[8] = '{
    '{5'd7,  3'b000, 2'd1, 32'h0000_8000, 32'hFFFF_FF80},
    '{5'd8,  3'b100, 2'd1, 32'h0000_8000, 32'h0000_0080},
    '{5'd9,  3'b001, 2'd2, 32'h8001_0000, 32'hFFFF_8001},
    '{5'd10, 3'b101, 2'd2, 32'h8001_0000, 32'h0000_8001},
    '{5'd11, 3'b010, 2'd3, 32'hDEAD_BEEF, 32'hDEAD_BEEF},
    '{5'd12, 3'b011, 2'd0, 32'h1234_5678, 32'h1234_5678},
    '{5'd13, 3'b001, 2'd3, 32'h8001_0000, 32'hFFFF_8001},
    '{5'd14, 3'b000, 2'd3, 32'h80FF_0000, 32'hFFFF_FF80}
  };
  qar_writeback dut (
    .clk(clk), .rst(rst), .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_rd(alu_rd),
    .alu_data(alu_data), .lsu_valid(lsu_valid), .lsu_ready(lsu_ready), .lsu_rd(lsu_rd),
    .lsu_rdata(lsu_rdata), .lsu_funct3(lsu_funct3), .lsu_addr_lo(lsu_addr_lo), .wb_hold(wb_hold),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .retire_count(retire_count)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic tick();
    logic [36:0] e;
    @(posedge clk);
    #1;
    if (rf_we) begin
      chk("sb_write_expected", 64'(exp_q.size() != 0), 64'd1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("sb_write", {27'd0, rf_waddr, rf_wdata}, {27'd0, e});
      end
    end
  endtask
  task automatic drive_ld(input ld_t l);
    lsu_valid = 1;
    lsu_rd = l.rd;
    lsu_funct3 = l.f3;
    lsu_addr_lo = l.off;
    lsu_rdata = l.rdata;
  endtask
  initial begin
    alu_valid = 1;
    lsu_valid = 1;
    #1;
    chk("rst_alu_ready", 64'(alu_ready), 0);
    chk("rst_lsu_ready", 64'(lsu_ready), 0);
    tick();
    tick();
    chk("rst_we", 64'(rf_we), 0);
    chk("rst_waddr", 64'(rf_waddr), 0);
    chk("rst_wdata", 64'(rf_wdata), 0);
    chk("rst_retire", 64'(retire_count), 0);
    alu_valid = 0;
    lsu_valid = 0;
    rst = 0;
    tick();
    alu_valid = 1; alu_rd = 5; alu_data = 123;
    #1;
    chk("alu_ready_rd5", 64'(alu_ready), 1);
    exp_q.push_back({5'd5, 32'd123});
    tick();
    chk("alu_we_rd5", 64'(rf_we), 1);
    alu_valid = 0;
    tick();
    chk("alu_we_drop", 64'(rf_we), 0);
    chk("retire_1", 64'(retire_count), 1);
    alu_valid = 1; alu_rd = 0; alu_data = 999;
    #1;
    chk("alu_ready_rd0", 64'(alu_ready), 1);
    tick();
    alu_valid = 0;
    chk("rd0_no_we", 64'(rf_we), 0);
    chk("retire_2", 64'(retire_count), 2);
    foreach (lds[i]) begin
      drive_ld(lds[i]);
      exp_q.push_back({lds[i].rd, lds[i].res});
      #1;
      chk("ld_lsu_ready", 64'(lsu_ready), 1);
      tick();
    end
    lsu_valid = 0;
    repeat (3) tick();
    chk("retire_10", 64'(retire_count), 10);
    // Starvation: prefill one load, then ALU and LSU both valid every cycle.
    drive_ld('{5'd21, F3_LW, 2'd0, 32'h100, 32'h100});
    tick();
    for (int i = 0; i < 4; i++) exp_q.push_back({5'(21 + i), 32'h100 + 32'(i)});
    exp_q.push_back({5'd30, 32'hA0});
    exp_q.push_back({5'd25, 32'h104});
    exp_q.push_back({5'd26, 32'h105});
    alu_valid = 1; alu_rd = 30; alu_data = 32'hA0;
    for (int i = 1; i <= 5; i++) begin
      drive_ld('{5'(21 + i), F3_LW, 2'd0, 32'h100 + 32'(i), 32'h0});
      #1;
      chk("starve_alu_ready", 64'(alu_ready), i == 5 ? 64'd1 : 64'd0);
      tick();
    end
    alu_valid = 0;
    lsu_valid = 0;
    #1;
    chk("starve_full", 64'(lsu_ready), 0);
    repeat (3) tick();
    chk("retire_17", 64'(retire_count), 17);
    wb_hold = 1;
    drive_ld('{5'd1, F3_LW, 2'd0, 32'h11, 32'h0});
    tick();
    drive_ld('{5'd2, F3_LW, 2'd0, 32'h22, 32'h0});
    tick();
    chk("hold_no_we", 64'(rf_we), 0);
    alu_valid = 1; alu_rd = 3;
    #1;
    chk("hold_lsu_ready", 64'(lsu_ready), 0);
    chk("hold_alu_ready", 64'(alu_ready), 0);
    exp_q.push_back({5'd1, 32'h11});
    exp_q.push_back({5'd2, 32'h22});
    alu_valid = 0;
    lsu_valid = 0;
    wb_hold = 0;
    tick();
    chk("release_we1", 64'(rf_we), 1);
    tick();
    chk("release_we2", 64'(rf_we), 1);
    chk("retire_19", 64'(retire_count), 19);
    wb_hold = 1;
    drive_ld('{5'd3, F3_LW, 2'd0, 32'h33, 32'h0});
    tick();
    drive_ld('{5'd4, F3_LW, 2'd0, 32'h44, 32'h0});
    tick();
    lsu_valid = 0;
    #1;
    chk("pre_rst_full", 64'(lsu_ready), 0);
    rst = 1;
    tick();
    rst = 0;
    wb_hold = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("post_rst_no_we", 64'(rf_we), 0);
    end
    chk("post_rst_lsu_ready", 64'(lsu_ready), 1);
    chk("post_rst_retire", 64'(retire_count), 0);
    chk("sb_drained", 64'(exp_q.size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
